// File: rtl/uart_tx_fifo.sv
// Store-bus UART transmitter: byte stores to TX_ADDR are queued in a small FIFO
// and serialised as 8N1 frames on a registered, glitch-free tx line.
module uart_tx_fifo #(
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 16,
    parameter logic [31:0] TX_ADDR      = 32'hFFFFFFFC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wData,
    input  logic [2:0]  size,
    input  logic        wEn,
    output logic        uartFifoFull,
    output logic        tx,
    output logic        txBusy
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic [CW-1:0] BAUD_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BAUD_ONE   = CW'(1);
    localparam logic [CW-1:0] BAUD_ZERO  = CW'(0);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [AW-1:0] PTR_ZERO   = AW'(0);
    localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
    localparam logic [AW:0]   CNT_ZERO   = (AW+1)'(0);
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(FIFO_DEPTH);

    logic [7:0]    mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic [1:0]    state_r;
    logic [CW-1:0] baud_r;
    logic [2:0]    bit_idx_r;
    logic [7:0]    shift_r;
    logic          tx_r;

    logic size_ok_s;
    logic push_s;
    logic pop_s;
    logic bit_done_s;
    logic fifo_full_s;
    logic fifo_empty_s;
    logic unused_wdata_s;

    // Only byte, half and word store codes address the data register.
    always_comb begin
        size_ok_s = 1'b0;
        case (size)
            3'b000, 3'b001, 3'b010: size_ok_s = 1'b1;
            default:                size_ok_s = 1'b0;
        endcase
    end

    // Fullness uses the pre-edge count, so a push that meets a pop while full is dropped.
    always_comb begin
        fifo_full_s  = (count_r == FULL_COUNT);
        fifo_empty_s = (count_r == CNT_ZERO);
        bit_done_s   = (baud_r == BAUD_LAST);
        push_s       = wEn && (addr == TX_ADDR) && size_ok_s && !fifo_full_s;
    end

    // A frame is popped from IDLE, or on the last STOP cycle for back-to-back frames.
    always_comb begin
        pop_s = 1'b0;
        case (state_r)
            ST_IDLE: pop_s = !fifo_empty_s;
            ST_STOP: pop_s = bit_done_s && !fifo_empty_s;
            default: pop_s = 1'b0;
        endcase
    end

    // FIFO storage; contents need no reset because the pointers and count do.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wData[7:0];
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Frame sequencer: baud counter, bit index and LSB-first shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            baud_r    <= BAUD_ZERO;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    baud_r    <= BAUD_ZERO;
                    bit_idx_r <= 3'd0;
                    if (pop_s) begin
                        shift_r <= mem_r[rd_ptr_r];
                        state_r <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_done_s) begin
                        baud_r  <= BAUD_ZERO;
                        state_r <= ST_DATA;
                    end else begin
                        baud_r <= baud_r + BAUD_ONE;
                    end
                end
                ST_DATA: begin
                    if (bit_done_s) begin
                        baud_r  <= BAUD_ZERO;
                        shift_r <= {1'b0, shift_r[7:1]};
                        if (bit_idx_r == 3'd7) begin
                            bit_idx_r <= 3'd0;
                            state_r   <= ST_STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        baud_r <= baud_r + BAUD_ONE;
                    end
                end
                ST_STOP: begin
                    if (bit_done_s) begin
                        baud_r    <= BAUD_ZERO;
                        bit_idx_r <= 3'd0;
                        if (pop_s) begin
                            shift_r <= mem_r[rd_ptr_r];
                            state_r <= ST_START;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        baud_r <= baud_r + BAUD_ONE;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    baud_r    <= BAUD_ZERO;
                    bit_idx_r <= 3'd0;
                end
            endcase
        end
    end

    // Line register: tx follows the state one cycle later so it never glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_r <= 1'b1;
        end else begin
            case (state_r)
                ST_START: tx_r <= 1'b0;
                ST_DATA:  tx_r <= shift_r[0];
                default:  tx_r <= 1'b1;
            endcase
        end
    end

    assign unused_wdata_s = ^wData[31:8];
    assign tx             = tx_r;
    assign uartFifoFull   = fifo_full_s;
    assign txBusy         = (state_r != ST_IDLE) || !fifo_empty_s;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a queue-and-timeline model predicts the
// line every cycle, and a sampling receiver decodes frames for literal checks.
module tb_uart_tx_fifo;
    localparam int          CPB   = 4;
    localparam int          DEPTH = 4;
    localparam logic [31:0] TXA   = 32'hFFFFFFFC;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wData;
    logic [2:0]  size;
    logic        wEn;
    logic        uartFifoFull;
    logic        tx;
    logic        txBusy;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .TX_ADDR(TXA)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wData(wData), .size(size), .wEn(wEn),
        .uartFifoFull(uartFifoFull), .tx(tx), .txBusy(txBusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a byte queue plus the number of cycles left in the frame on the line.
    logic [7:0] mq[$];
    logic [7:0] m_frame;
    int         remaining = 0;
    logic       m_tx = 1'b1;
    logic       m_busy = 1'b0;
    logic       m_full = 1'b0;
    logic       model_valid = 1'b0;
    logic       last_rst = 1'b0;

    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return b[idx-1];
    endfunction

    initial begin : model
        logic acc;
        logic pop;
        forever begin
            @(posedge clk);
            if (rst) begin
                mq.delete();
                remaining = 0;
                m_tx      = 1'b1;
                last_rst  = 1'b1;
            end else begin
                last_rst = 1'b0;
                m_tx = (remaining > 0) ? frame_bit(m_frame, (10*CPB - remaining) / CPB) : 1'b1;
                acc  = wEn && (addr == TXA) && (size <= 3'd2) && (mq.size() < DEPTH);
                pop  = (remaining <= 1) && (mq.size() > 0);
                if (pop) begin
                    m_frame   = mq.pop_front();
                    remaining = 10*CPB;
                end else if (remaining > 0) begin
                    remaining--;
                end
                if (acc) mq.push_back(wData[7:0]);
            end
            m_busy      = (remaining > 0) || (mq.size() > 0);
            m_full      = (mq.size() == DEPTH);
            model_valid = 1'b1;
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (model_valid) begin
                check("tx", tx, m_tx);
                check("txBusy", txBusy, m_busy);
                check("uartFifoFull", uartFifoFull, m_full);
            end
        end
    end

    // Receiver: mid-bit sampling of the line, independent of the model.
    logic [7:0] rx_q[$];
    logic [7:0] rx_byte;
    logic       rx_active = 1'b0;
    int         rx_n = 0;

    initial begin : receiver
        forever begin
            @(negedge clk);
            if (last_rst) begin
                rx_active = 1'b0;
            end else if (!rx_active) begin
                if (model_valid && tx === 1'b0) begin
                    rx_active = 1'b1;
                    rx_n      = 0;
                end
            end else begin
                rx_n++;
                if ((rx_n % CPB) == CPB/2 && rx_n/CPB >= 1 && rx_n/CPB <= 8)
                    rx_byte[rx_n/CPB - 1] = tx;
                if (rx_n == 9*CPB + CPB/2) begin
                    check("stop_bit", tx, 1'b1);
                    rx_q.push_back(rx_byte);
                    rx_active = 1'b0;
                end
            end
        end
    end

    int rx_rd = 0;

    task automatic expect_rx(input string name, input logic [7:0] b);
        if (rx_rd < rx_q.size()) begin
            check(name, rx_q[rx_rd], b);
            rx_rd++;
        end else begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no byte received, expected %02h", name, b);
        end
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] s);
        addr  = a;
        wData = d;
        size  = s;
        wEn   = 1'b1;
        @(negedge clk);
        wEn = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (txBusy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (n >= budget) begin
            n_bad++;
            $display("FAIL %s: txBusy still %b after %0d cycles, expected 0", name, txBusy, budget);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin : stimulus
        int dens;
        rst = 1'b1; wEn = 1'b0; addr = 32'h0; wData = 32'h0; size = 3'b000;
        repeat (3) @(negedge clk);
        check("reset_tx", tx, 1'b1);
        check("reset_busy", txBusy, 1'b0);
        check("reset_full", uartFifoFull, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Single byte 0x55: alternating 0/1 line, each bit 4 cycles.
        store(TXA, 32'h00000055, 3'b000);
        @(negedge clk);
        check("sb55_pre_start", tx, 1'b1);
        for (int j = 0; j < 10*CPB; j++) begin
            @(negedge clk);
            check("sb55_line", tx, logic'((j / CPB) % 2));
            if (j == 10*CPB - 2) check("sb55_busy_last", txBusy, 1'b1);
            if (j == 10*CPB - 1) check("sb55_busy_clear", txBusy, 1'b0);
        end
        wait_idle("sb55_idle", 100);
        expect_rx("sb55_rx", 8'h55);

        // Back-to-back SW then SH.
        store(TXA, 32'h12345AA1, 3'b010);
        store(TXA, 32'h0000FF0F, 3'b001);
        wait_idle("b2b_idle", 200);
        expect_rx("b2b_rx0", 8'hA1);
        expect_rx("b2b_rx1", 8'h0F);

        // Full and drop: burst lands so the 6th store meets the first pop while full.
        store(TXA, 32'h000000EE, 3'b000);
        repeat (10*CPB - 5) @(negedge clk);
        for (int i = 1; i <= 4; i++) store(TXA, i, 3'b000);
        check("full_after_4", uartFifoFull, 1'b1);
        store(TXA, 32'h00000005, 3'b000);
        store(TXA, 32'h00000006, 3'b000);
        check("full_after_pop", uartFifoFull, 1'b0);
        wait_idle("full_idle", 400);
        expect_rx("full_rx0", 8'hEE);
        for (int i = 1; i <= 4; i++) expect_rx("full_rx", 8'(i));

        // Decode filter.
        store(32'hFFFFFFF8, 32'h00000041, 3'b000);
        store(32'h00000100, 32'h00000042, 3'b000);
        store(TXA, 32'h00000043, 3'b011);
        store(TXA, 32'h00000044, 3'b111);
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            check("filter_tx", tx, 1'b1);
            check("filter_busy", txBusy, 1'b0);
        end
        check("filter_rx_none", rx_q.size(), rx_rd);

        // Simultaneous push/pop at count 2 (pointers wrap by now).
        store(TXA, 32'h000000A0, 3'b000);
        store(TXA, 32'h000000A1, 3'b000);
        store(TXA, 32'h000000A2, 3'b000);
        repeat (10*CPB - 2) @(negedge clk);
        store(TXA, 32'h000000A3, 3'b000);
        check("pushpop_not_full", uartFifoFull, 1'b0);
        wait_idle("pushpop_idle", 400);
        for (int i = 0; i < 4; i++) expect_rx("pushpop_rx", 8'hA0 + 8'(i));

        // Reset in the middle of data bit 3 with three bytes queued.
        store(TXA, 32'h000000B0, 3'b000);
        store(TXA, 32'h000000B1, 3'b000);
        store(TXA, 32'h000000B2, 3'b000);
        store(TXA, 32'h000000B3, 3'b000);
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_tx", tx, 1'b1);
        check("rst_mid_busy", txBusy, 1'b0);
        check("rst_mid_full", uartFifoFull, 1'b0);
        repeat (60) @(negedge clk);
        check("rst_quiet_tx", tx, 1'b1);
        check("rst_quiet_busy", txBusy, 1'b0);
        check("rst_rx_none", rx_q.size(), rx_rd);

        // Randomised traffic in three density phases; the model checks every cycle.
        for (int ph = 0; ph < 3; ph++) begin
            dens = (ph == 0) ? 80 : ((ph == 1) ? 8 : 45);
            for (int i = 0; i < 500; i++) begin
                rst   = ($urandom_range(0, 299) == 0);
                wEn   = ($urandom_range(0, 99) < dens);
                addr  = ($urandom_range(0, 9) < 8) ? TXA :
                        (($urandom_range(0, 1) == 0) ? 32'hFFFFFFF8 : $urandom);
                size  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
                wData = $urandom;
                @(negedge clk);
            end
        end
        rst = 1'b0;
        wEn = 1'b0;
        wait_idle("random_drain", 10*CPB*(DEPTH+2) + 50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
